// File: rtl/tdm_demux_pkg.sv
// ============================================================================
// Module      : tdm_demux_pkg
// Description : Shared definitions for the TDM receive demultiplexer.
//               Provides the framer state encoding, default geometry, and a
//               helper that locates channel k inside a packed frame vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tdm_demux_pkg;

    localparam int DEF_NCH = 4;
    localparam int DEF_W   = 8;

    // HUNT: waiting for a channel-0 (frame_sync) sample.
    // COLLECT: assembling channels 1..NCH-1 of the current frame.
    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } tdm_state_t;

    // LSB position of channel k in a frame vector of w-bit samples.
    function automatic int ch_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tdm_frame_counter.sv
// ============================================================================
// Module      : tdm_frame_counter
// Description : Channel index counter for the TDM demultiplexer.
//               Priority: clr > load1 > inc. The index wraps naturally
//               because NCH is a power of two.
// Ports       : clk   - rising-edge clock
//               rst_n - synchronous active-low reset (idx -> 0)
//               inc   - advance to the next channel
//               load1 - channel 0 was just stored; next slot is channel 1
//               clr   - return to channel 0
//               idx   - channel slot the next valid sample belongs to
//               last  - idx points at the final channel of the frame
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_frame_counter
    import tdm_demux_pkg::*;
#(
    parameter  int NCH = DEF_NCH,
    localparam int CW  = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          load1,
    input  logic          clr,
    output logic [CW-1:0] idx,
    output logic          last
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (load1) begin
            idx <= CW'(1);
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

    assign last = (idx == CW'(NCH - 1));

endmodule

`default_nettype wire

// File: rtl/tdm_demux.sv
// ============================================================================
// Module      : tdm_demux
// Description : Receive side of a TDM link. Deserializes NCH W-bit samples
//               per frame (channel 0 marked by frame_sync) into a parallel,
//               registered frame with a one-cycle frame_valid strobe.
//               Framing violations pulse sync_err and latch err_sticky.
// Ports       : clk         - rising-edge clock
//               rst_n       - synchronous active-low reset
//               din         - multiplexed sample
//               din_valid   - din carries a sample this cycle
//               frame_sync  - with din_valid, marks the channel-0 sample
//               dout        - last complete frame, channel k at [k*W +: W]
//               frame_valid - one-cycle pulse when dout takes a new frame
//               sync_err    - one-cycle pulse on a framing violation
//               err_sticky  - set by any sync_err, cleared only by reset
//               chsel/dsel  - (TDM_DEMUX_CHSEL_EN only) channel-select view
//                             of dout, combinational from the registers
// Build macro : TDM_DEMUX_CHSEL_EN adds chsel/dsel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter  int NCH = DEF_NCH,
    parameter  int W   = DEF_W,
    localparam int CW  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    input  logic             frame_sync,
`ifdef TDM_DEMUX_CHSEL_EN
    input  logic [CW-1:0]    chsel,
    output logic [W-1:0]     dsel,
`endif
    output logic [NCH*W-1:0] dout,
    output logic             frame_valid,
    output logic             sync_err,
    output logic             err_sticky
);

    tdm_state_t   state;
    logic [W-1:0] shadow [NCH-1];
    logic [CW-1:0] idx;
    logic          last;

    logic          early_sync;
    logic          missing_sync;
    logic          cnt_inc;
    logic          cnt_load1;
    logic          cnt_clr;
    logic [NCH*W-1:0] frame_next;

    // A sync in the middle of a frame restarts it; a non-sync sample where
    // channel 0 is expected means framing was lost.
    assign early_sync   = din_valid && (state == COLLECT) && frame_sync && (idx != '0);
    assign missing_sync = din_valid && (state == COLLECT) && !frame_sync && (idx == '0);

    // Every accepted sync sample leaves the next slot at channel 1,
    // whether it starts, restarts, or continues framing.
    assign cnt_load1 = din_valid && frame_sync;
    assign cnt_clr   = missing_sync;
    assign cnt_inc   = din_valid && !frame_sync && (state == COLLECT) && (idx != '0);

    tdm_frame_counter #(
        .NCH   (NCH)
    ) u_frame_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .load1 (cnt_load1),
        .clr   (cnt_clr),
        .idx   (idx),
        .last  (last)
    );

    // The final channel goes straight from din into dout, so the shadow
    // only needs to hold the first NCH-1 samples.
    for (genvar k = 0; k < NCH - 1; k++) begin : g_frame
        assign frame_next[ch_lsb(k, W) +: W] = shadow[k];
    end
    assign frame_next[ch_lsb(NCH - 1, W) +: W] = din;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= HUNT;
            dout        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            err_sticky  <= 1'b0;
            for (int k = 0; k < NCH - 1; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (din_valid) begin
                case (state)
                    HUNT: begin
                        if (frame_sync) begin
                            shadow[0] <= din;
                            state     <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (early_sync) begin
                            sync_err   <= 1'b1;
                            err_sticky <= 1'b1;
                            shadow[0]  <= din;
                        end else if (missing_sync) begin
                            sync_err   <= 1'b1;
                            err_sticky <= 1'b1;
                            state      <= HUNT;
                        end else if (last) begin
                            dout        <= frame_next;
                            frame_valid <= 1'b1;
                        end else begin
                            shadow[idx] <= din;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

`ifdef TDM_DEMUX_CHSEL_EN
    assign dsel = dout[32'(chsel) * W +: W];
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux.sv
// ============================================================================
// Module      : tb_tdm_demux
// Description : Self-checking bench for tdm_demux (NCH=4, W=8). Directed
//               scenarios followed by randomized traffic compared against a
//               queue-based frame model. Covers TDM_DEMUX_CHSEL_EN when set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int CW  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [W-1:0]     din = '0;
    logic             din_valid = 1'b0;
    logic             frame_sync = 1'b0;
    logic [NCH*W-1:0] dout;
    logic             frame_valid;
    logic             sync_err;
    logic             err_sticky;
`ifdef TDM_DEMUX_CHSEL_EN
    logic [CW-1:0]    chsel = '0;
    logic [W-1:0]     dsel;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    tdm_demux #(.NCH(NCH), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
`ifdef TDM_DEMUX_CHSEL_EN
        .chsel       (chsel),
        .dsel        (dsel),
`endif
        .dout        (dout),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Framing is described as a list of samples gathered since the last
    // channel-0 sample; no list means the receiver is hunting for sync.
    bit                m_hunt = 1'b1;
    logic [W-1:0]      m_q[$];
    logic [NCH*W-1:0]  m_dout = '0;
    bit                m_fv = 1'b0;
    bit                m_se = 1'b0;
    bit                m_sticky = 1'b0;

    task automatic model_step(input bit rst, input bit v, input bit s, input logic [W-1:0] d);
        m_fv = 1'b0;
        m_se = 1'b0;
        if (rst) begin
            m_hunt = 1'b1; m_q.delete(); m_dout = '0; m_sticky = 1'b0;
            return;
        end
        if (!v) return;
        if (m_hunt) begin
            if (s) begin m_hunt = 1'b0; m_q.delete(); m_q.push_back(d); end
            return;
        end
        if (s && m_q.size() != 0) begin
            m_se = 1'b1; m_sticky = 1'b1; m_q.delete(); m_q.push_back(d);
        end else if (!s && m_q.size() == 0) begin
            m_se = 1'b1; m_sticky = 1'b1; m_hunt = 1'b1;
        end else begin
            m_q.push_back(d);
            if (m_q.size() == NCH) begin
                for (int k = 0; k < NCH; k++) m_dout[k*W +: W] = m_q[k];
                m_fv = 1'b1;
                m_q.delete();
            end
        end
    endtask

    // Apply one cycle of inputs; returns with outputs settled after the edge.
    task automatic step(input bit v, input bit s, input logic [W-1:0] d);
        din_valid = v; frame_sync = s; din = d;
        @(posedge clk); #1;
        model_step(!rst_n, v, s, d);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        checks++;
        if (dout !== '0 || frame_valid !== 1'b0 || sync_err !== 1'b0 || err_sticky !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: dout=%h fv=%b se=%b sticky=%b expected all zero",
                     dout, frame_valid, sync_err, err_sticky);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'($urandom));
            checks++;
            if (dout !== '0 || frame_valid !== 1'b0 || err_sticky !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold[%0d]: dout=%h fv=%b sticky=%b expected 0/0/0",
                         i, dout, frame_valid, err_sticky);
            end
        end
    endtask

    task automatic test_clean_frame();
        logic [W-1:0] smp [NCH];
        smp[0] = 8'h11; smp[1] = 8'h22; smp[2] = 8'h33; smp[3] = 8'h44;
        for (int i = 0; i < NCH; i++) begin
            step(1, i == 0, smp[i]);
            checks++;
            if (sync_err !== 1'b0 || frame_valid !== (i == NCH - 1)) begin
                failures++;
                $display("FAIL clean_strobes[%0d]: fv=%b se=%b expected fv=%b se=0",
                         i, frame_valid, sync_err, i == NCH - 1);
            end
        end
        checks++;
        if (dout !== 32'h44332211) begin
            failures++;
            $display("FAIL clean_dout: got %h expected 44332211", dout);
        end
        step(0, 0, 8'h00);
        checks++;
        if (frame_valid !== 1'b0 || dout !== 32'h44332211) begin
            failures++;
            $display("FAIL clean_hold: fv=%b dout=%h expected 0/44332211", frame_valid, dout);
        end
`ifdef TDM_DEMUX_CHSEL_EN
        for (int c = 0; c < NCH; c++) begin
            chsel = CW'(c);
            #1;
            checks++;
            if (dsel !== smp[c]) begin
                failures++;
                $display("FAIL chsel[%0d]: dsel=%h expected %h", c, dsel, smp[c]);
            end
        end
`endif
    endtask

    task automatic test_gapped_b2b();
        int t1;
        int t2;
        step(1, 1, 8'hA0); step(0, 0, 8'hFF);
        step(1, 0, 8'hA1); step(0, 1, 8'hEE);
        step(1, 0, 8'hA2); step(1, 0, 8'hA3);
        t1 = cyc;
        checks++;
        if (frame_valid !== 1'b1 || dout !== 32'hA3A2A1A0) begin
            failures++;
            $display("FAIL gapped_frame: fv=%b dout=%h expected 1/a3a2a1a0", frame_valid, dout);
        end
        t2 = -1;
        for (int i = 0; i < NCH; i++) begin
            step(1, i == 0, 8'hB0 + 8'(i));
            if (frame_valid === 1'b1) t2 = cyc;
        end
        checks++;
        if (t2 - t1 !== NCH) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d cycles expected %0d", t2 - t1, NCH);
        end
        checks++;
        if (dout !== 32'hB3B2B1B0) begin
            failures++;
            $display("FAIL b2b_dout: got %h expected b3b2b1b0", dout);
        end
    endtask

    task automatic test_early_sync();
        logic [W-1:0] d [6];
        bit s [6];
        int fv_cnt;
        d = '{8'h01, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40};
        s = '{1, 0, 1, 0, 0, 0};
        fv_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, s[i], d[i]);
            if (frame_valid === 1'b1) fv_cnt++;
            checks++;
            if (sync_err !== (i == 2)) begin
                failures++;
                $display("FAIL early_sync_err[%0d]: se=%b expected %b", i, sync_err, i == 2);
            end
            if (i == 2) begin
                checks++;
                if (err_sticky !== 1'b1 || frame_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL early_sticky: sticky=%b fv=%b expected 1/0", err_sticky, frame_valid);
                end
            end
        end
        checks++;
        if (fv_cnt !== 1 || dout !== 32'h40302010) begin
            failures++;
            $display("FAIL early_frame: pulses=%0d dout=%h expected 1/40302010", fv_cnt, dout);
        end
    endtask

    task automatic test_missing_sync_reset();
        for (int i = 0; i < NCH; i++) step(1, i == 0, 8'hC0 + 8'(i));
        step(1, 0, 8'h55);
        checks++;
        if (sync_err !== 1'b1 || frame_valid !== 1'b0 || dout !== 32'hC3C2C1C0) begin
            failures++;
            $display("FAIL missing_sync: se=%b fv=%b dout=%h expected 1/0/c3c2c1c0",
                     sync_err, frame_valid, dout);
        end
        // Hunting now: further unsynced samples are silently dropped.
        step(1, 0, 8'h56);
        checks++;
        if (sync_err !== 1'b0) begin
            failures++;
            $display("FAIL hunt_silent: se=%b expected 0", sync_err);
        end
        step(1, 1, 8'h61);
        step(1, 0, 8'h62);
        rst_n = 1'b0;
        step(0, 0, 8'h00);
        rst_n = 1'b1;
        checks++;
        if (dout !== '0 || err_sticky !== 1'b0 || frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL midframe_reset: dout=%h sticky=%b fv=%b expected 0/0/0",
                     dout, err_sticky, frame_valid);
        end
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 8'h63 + 8'(i));
            checks++;
            if (frame_valid !== 1'b0 || sync_err !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_nosync[%0d]: fv=%b se=%b expected 0/0",
                         i, frame_valid, sync_err);
            end
        end
    endtask

    task automatic test_random();
        bit v;
        bit s;
        rst_n = 1'b0;
        step(0, 0, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            v = ($urandom % 4) != 0;
            if (m_hunt) s = ($urandom % 3) == 0;
            else        s = (m_q.size() == 0);
            if (($urandom % 12) == 0) s = !s;
            step(v, s, 8'($urandom));
            checks++;
            if (dout !== m_dout || frame_valid !== m_fv || sync_err !== m_se || err_sticky !== m_sticky) begin
                failures++;
                $display("FAIL random[%0d]: dout=%h fv=%b se=%b sticky=%b expected %h/%b/%b/%b",
                         i, dout, frame_valid, sync_err, err_sticky, m_dout, m_fv, m_se, m_sticky);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_gapped_b2b();
        test_early_sync();
        test_missing_sync_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive end of a time-division-multiplexed link; the counterpart to the 2:1/N:1 select-mux labs.
- A single W-bit stream carries NCH channel samples per frame. Channel 0 is marked by frame_sync.
- The block deserializes each frame into NCH parallel channel registers and presents a complete, stable frame with a one-cycle frame_valid strobe.
- Sits between the lab-level mux/serializer stimulus and the per-channel consumers.

Parameters:
- NCH, 4, number of channels per frame (power of 2, ≥2).
- W, 8, sample width in bits.
- CW, $clog2(NCH), channel index width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- din  input  W  multiplexed sample.
- din_valid  input  1  din holds a sample this cycle.
- frame_sync  input  1  qualified by din_valid; marks the channel-0 sample.
- dout  output  NCH*W  completed frame; channel k at bits [k*W +: W].
- frame_valid  output  1  one-cycle pulse: dout updated with a new frame.
- sync_err  output  1  one-cycle pulse on a framing violation.
- err_sticky  output  1  set by any sync_err; cleared only by reset.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=HUNT, idx=0, shadow registers=0.
  - dout=0, frame_valid=0, sync_err=0, err_sticky=0.
  - Reset overrides any in-flight frame; the partial frame is discarded.
- Samples are accepted only on cycles with din_valid=1. din_valid=0 cycles are idle and change nothing.
- HUNT:
  - Valid without sync: discard the sample, no error.
  - Valid with sync: shadow[0]=din, idx=1, go to COLLECT.
- COLLECT, valid sample:
  - sync=1 and idx≠0 (early sync): pulse sync_err, shadow[0]=din, idx=1, stay in COLLECT. The partial frame is dropped.
  - sync=0 and idx=0 (missing sync): pulse sync_err, discard the sample, go to HUNT.
  - Otherwise: shadow[idx]=din.
    - If idx=NCH-1: copy shadow (including the current din) to dout and pulse frame_valid on the next cycle. idx wraps to 0.
    - Else: idx=idx+1.
- Latency: dout and frame_valid change in the cycle after the edge that accepted the last sample (registered outputs).
- dout holds its value until the next complete frame. A partial or erroneous frame never reaches dout.
- Back-to-back frames with no idle cycles produce one frame_valid every NCH cycles.
- sync_err and frame_valid cannot both assert for the same sample.
- err_sticky is set in the same cycle sync_err asserts.

Optional Feature:
- Macro: TDM_DEMUX_CHSEL_EN.
- Defined:
  - Adds input chsel [CW] and output dsel [W].
  - dsel = dout channel chsel, combinational from the registered dout (this is the mux view of the frame).
  - Out-of-range values are impossible because NCH is a power of 2.
- Undefined: the ports are absent; no other behaviour changes.

Decomposition:
- Shared header tdm_defs.vh (the team's package equivalent) holds:
  - state encodings HUNT=1'b0 and COLLECT=1'b1;
  - default NCH/W localparams;
  - a channel-slice macro.
- Sub-module tdm_frame_counter:
  - holds idx and the wrap/last-sample flag;
  - inputs: clk, rst_n, inc, load1, clr;
  - outputs: idx, last.
- tdm_demux instantiates tdm_frame_counter and keeps the FSM, shadow registers and output registers itself.

Test Plan (NCH=4, W=8):
1. Reset then idle. rst_n=0 for 2 cycles, din_valid=0 → dout=0, frame_valid=0, err_sticky=0; these hold for 10 idle cycles.
2. Clean frame. Valid samples 0x11(sync),0x22,0x33,0x44 on consecutive cycles → one frame_valid pulse 1 cycle after 0x44; dout=0x44332211; sync_err never asserts.
3. Gapped frame then back-to-back frames.
   - 0xA0(sync),idle,0xA1,idle,0xA2,0xA3 → dout=0xA3A2A1A0.
   - Immediately after: 0xB0(sync)..0xB3 → second pulse exactly 4 cycles after the first; dout=0xB3B2B1B0.
4. Early sync. 0x01(sync),0x02,0x10(sync),0x20,0x30,0x40 → sync_err pulse on 0x10; err_sticky=1; a single frame_valid with dout=0x40302010.
5. Missing sync and reset mid-frame.
   - After a full frame, send 0x55 with no sync → sync_err; state=HUNT; 0x55 is dropped.
   - Then 0x61(sync),0x62, then rst_n=0 → dout=0, err_sticky=0.
   - After reset, 0x63,0x64 without sync → no frame_valid.
6. With TDM_DEMUX_CHSEL_EN defined, after test 2: chsel=0..3 → dsel=0x11,0x22,0x33,0x44. Undefined build compiles without chsel/dsel.
